branch_resolve_ctrl: RTL and testbench

Sequencer that resolves RV32I B-type branches (BEQ/BNE/BLT/BGE/BLTU/BGEU). It accepts an instruction word plus PC over a valid/ready handshake and splits the word into rs1, rs2 and the split immediate. It fetches both operands through one shared register-file read port using a request/grant handshake, then compares them and computes the target. The result (taken, target, exception flags) goes to the fetch-redirect logic over a valid/ready handshake.

---
 rtl/branch_resolve_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_branch_resolve_ctrl.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_ctrl.sv
// ---------------------------------------------------------------------------
// branch_resolve_ctrl
//
// Resolves one RV32I B-type branch (BEQ/BNE/BLT/BGE/BLTU/BGEU) at a time.
// An instruction word and its PC are accepted in IDLE. The block then reads
// rs1 and rs2 through one shared register-file read port, evaluates the
// branch condition, and presents taken/target/exception flags until the
// consumer accepts them.
//
// Ports:
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   in_valid/ready  instruction handshake (in_ready high only in IDLE)
//   in_instr, in_pc instruction word and its PC
//   rf_req/rf_addr  register-file read request, held until rf_gnt
//   rf_gnt/rf_rdata grant and read data (data valid in the grant cycle)
//   out_valid/ready result handshake
//   out_taken       branch condition true
//   out_target      in_pc + sext(imm), wrapping
//   out_illegal     not a B-type opcode, or funct3 in {010, 011}
//   out_misaligned  taken branch to a target with target[1:0] != 0
//                   (only when IALIGN_CHECK = 1)
// ---------------------------------------------------------------------------
module branch_resolve_ctrl #(
  parameter int unsigned XLEN         = 32,
  parameter bit          IALIGN_CHECK = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            rf_req,
  output logic [4:0]      rf_addr,
  input  logic            rf_gnt,
  input  logic [XLEN-1:0] rf_rdata,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            out_taken,
  output logic [XLEN-1:0] out_target,
  output logic            out_illegal,
  output logic            out_misaligned
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RD1  = 3'd1;
  localparam logic [2:0] S_RD2  = 3'd2;
  localparam logic [2:0] S_EXEC = 3'd3;
  localparam logic [2:0] S_RESP = 3'd4;

  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // Reassemble the split B-type immediate and sign-extend from bit 12.
  function automatic logic [XLEN-1:0] imm_sext(input logic [31:0] w);
    logic [12:0] imm;
    imm = {w[31], w[7], w[30:25], w[11:8], 1'b0};
    return {{(XLEN-13){imm[12]}}, imm};
  endfunction

  function automatic logic is_illegal(input logic [31:0] w);
    return (w[6:0] != OPC_BRANCH) || (w[14:12] == 3'b010) || (w[14:12] == 3'b011);
  endfunction

  logic [2:0]      state_q,    state_d;
  logic [4:0]      rs1_q,      rs1_d;
  logic [4:0]      rs2_q,      rs2_d;
  logic [2:0]      funct3_q,   funct3_d;
  logic [XLEN-1:0] op1_q,      op1_d;
  logic [XLEN-1:0] op2_q,      op2_d;
  logic [XLEN-1:0] target_q,   target_d;
  logic            taken_q,    taken_d;
  logic            illegal_q,  illegal_d;
  logic            misalign_q, misalign_d;

  logic            cond;

  // Branch condition on the captured operands.
  always_comb begin
    cond = 1'b0;
    case (funct3_q)
      F3_BEQ:  cond = (op1_q == op2_q);
      F3_BNE:  cond = (op1_q != op2_q);
      F3_BLT:  cond = ($signed(op1_q) <  $signed(op2_q));
      F3_BGE:  cond = ($signed(op1_q) >= $signed(op2_q));
      F3_BLTU: cond = (op1_q <  op2_q);
      F3_BGEU: cond = (op1_q >= op2_q);
      default: cond = 1'b0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    rs1_d      = rs1_q;
    rs2_d      = rs2_q;
    funct3_d   = funct3_q;
    op1_d      = op1_q;
    op2_d      = op2_q;
    target_d   = target_q;
    taken_d    = taken_q;
    illegal_d  = illegal_q;
    misalign_d = misalign_q;
    rf_req     = 1'b0;
    rf_addr    = '0;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          // Only the decoded fields are kept; the target is formed here so
          // the illegal path (which skips EXEC) still reports it.
          rs1_d      = in_instr[19:15];
          rs2_d      = in_instr[24:20];
          funct3_d   = in_instr[14:12];
          target_d   = in_pc + imm_sext(in_instr);
          illegal_d  = is_illegal(in_instr);
          taken_d    = 1'b0;
          misalign_d = 1'b0;
          op1_d      = '0;
          op2_d      = '0;
          state_d    = is_illegal(in_instr) ? S_RESP : S_RD1;
        end
      end

      S_RD1: begin
        if (rs1_q == 5'd0) begin
          op1_d   = '0;
          state_d = S_RD2;
        end else begin
          rf_req  = 1'b1;
          rf_addr = rs1_q;
          if (rf_gnt) begin
            op1_d   = rf_rdata;
            state_d = S_RD2;
          end
        end
      end

      S_RD2: begin
        if (rs2_q == 5'd0) begin
          op2_d   = '0;
          state_d = S_EXEC;
        end else begin
          rf_req  = 1'b1;
          rf_addr = rs2_q;
          if (rf_gnt) begin
            op2_d   = rf_rdata;
            state_d = S_EXEC;
          end
        end
      end

      S_EXEC: begin
        taken_d    = cond;
        misalign_d = IALIGN_CHECK && cond && (target_q[1:0] != 2'b00);
        state_d    = S_RESP;
      end

      S_RESP: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      rs1_q      <= '0;
      rs2_q      <= '0;
      funct3_q   <= '0;
      op1_q      <= '0;
      op2_q      <= '0;
      target_q   <= '0;
      taken_q    <= 1'b0;
      illegal_q  <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rs1_q      <= rs1_d;
      rs2_q      <= rs2_d;
      funct3_q   <= funct3_d;
      op1_q      <= op1_d;
      op2_q      <= op2_d;
      target_q   <= target_d;
      taken_q    <= taken_d;
      illegal_q  <= illegal_d;
      misalign_q <= misalign_d;
    end
  end

  assign in_ready       = (state_q == S_IDLE);
  assign out_valid      = (state_q == S_RESP);
  assign out_taken      = taken_q;
  assign out_target     = target_q;
  assign out_illegal    = illegal_q;
  assign out_misaligned = misalign_q;

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
module tb_branch_resolve_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        rf_req;
  logic [4:0]  rf_addr;
  logic        rf_gnt;
  logic [31:0] rf_rdata;
  logic        out_valid;
  logic        out_ready;
  logic        out_taken;
  logic [31:0] out_target;
  logic        out_illegal;
  logic        out_misaligned;

  branch_resolve_ctrl #(.XLEN(32), .IALIGN_CHECK(1'b1)) dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_instr       (in_instr),
    .in_pc          (in_pc),
    .rf_req         (rf_req),
    .rf_addr        (rf_addr),
    .rf_gnt         (rf_gnt),
    .rf_rdata       (rf_rdata),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_taken      (out_taken),
    .out_target     (out_target),
    .out_illegal    (out_illegal),
    .out_misaligned (out_misaligned)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        taken;
    logic [31:0] target;
    logic        illegal;
    logic        mis;
  } exp_t;

  exp_t        sb[$];
  logic [4:0]  addr_log[$];
  logic [31:0] rf_mem[32];
  int          total = 0;
  int          bad   = 0;
  int          req_cycles;
  int          wait_cnt;
  logic [4:0]  wait_addr;
  logic        addr_unstable;
  logic [4:0]  delay_addr;
  int          delay_val;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Register-file responder: grants after delay_val wait cycles for
  // delay_addr, immediately otherwise; logs granted addresses.
  initial begin
    rf_gnt = 1'b0;
    rf_rdata = '0;
    wait_cnt = 0;
    wait_addr = '0;
    forever begin
      @(posedge clk); #1;
      if (rf_req && !rst) begin
        req_cycles++;
        if (wait_cnt > 0 && rf_addr !== wait_addr) addr_unstable = 1'b1;
        wait_addr = rf_addr;
        if (wait_cnt >= ((rf_addr == delay_addr) ? delay_val : 0)) begin
          rf_gnt = 1'b1;
          rf_rdata = rf_mem[rf_addr];
          addr_log.push_back(rf_addr);
          wait_cnt = 0;
        end else begin
          rf_gnt = 1'b0;
          wait_cnt++;
        end
      end else begin
        rf_gnt = 1'b0;
        wait_cnt = 0;
      end
    end
  end

  task automatic run(input string name, input logic [31:0] instr, input logic [31:0] pc,
                     input int rdy_delay, input int exp_lat, input int exp_reqc,
                     input int exp_nreads, input logic [4:0] a0, input logic [4:0] a1,
                     input logic e_taken, input logic [31:0] e_target,
                     input logic e_ill, input logic e_mis);
    exp_t e, got;
    int lat;
    int n;
    logic [33:0] snap;
    n = 0;
    while (!in_ready && n < 20) begin @(posedge clk); #1; n++; end
    check({name, "_in_ready"}, in_ready, 1);
    addr_log.delete();
    req_cycles = 0;
    addr_unstable = 1'b0;
    sb.push_back('{taken: e_taken, target: e_target, illegal: e_ill, mis: e_mis});
    in_valid = 1'b1; in_instr = instr; in_pc = pc;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 40) begin @(posedge clk); #1; lat++; end
    if (!out_valid) begin
      check({name, "_timeout"}, out_valid, 1);
      void'(sb.pop_front());
      return;
    end
    check({name, "_latency"}, lat, exp_lat);
    check({name, "_req_cycles"}, req_cycles, exp_reqc);
    check({name, "_nreads"}, addr_log.size(), exp_nreads);
    if (addr_log.size() > 0) check({name, "_addr0"}, addr_log[0], a0);
    if (addr_log.size() > 1) check({name, "_addr1"}, addr_log[1], a1);
    check({name, "_addr_stable"}, addr_unstable, 0);
    e = sb.pop_front();
    got = '{taken: out_taken, target: out_target, illegal: out_illegal, mis: out_misaligned};
    check({name, "_taken"}, got.taken, e.taken);
    check({name, "_target"}, got.target, e.target);
    check({name, "_illegal"}, got.illegal, e.illegal);
    check({name, "_misaligned"}, got.mis, e.mis);
    snap = {out_taken, out_target, out_illegal};
    for (int i = 0; i < rdy_delay; i++) begin
      @(posedge clk); #1;
      check({name, "_hold"}, {out_valid, in_ready, out_taken, out_target, out_illegal, out_misaligned},
            {1'b1, 1'b0, snap, e.mis});
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({name, "_post_valid"}, out_valid, 0);
    check({name, "_post_ready"}, in_ready, 1);
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_instr = '0;
    in_pc = '0;
    out_ready = 1'b0;
    delay_addr = '0;
    delay_val = 0;
    req_cycles = 0;
    addr_unstable = 1'b0;
    for (int i = 0; i < 32; i++) rf_mem[i] = '0;
    rf_mem[1] = 32'h55;
    rf_mem[2] = 32'h55;
    rf_mem[3] = 32'hFFFF_FFFF;
    rf_mem[4] = 32'h1;
    rf_mem[5] = 32'h0;

    #3;
    check("rst_in_ready", in_ready, 1);
    check("rst_rf_req", rf_req, 0);
    check("rst_rf_addr", rf_addr, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_outs", {out_taken, out_target, out_illegal, out_misaligned}, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    run("beq",  32'h0020_8463, 32'h100, 0, 4, 2, 2, 5'd1, 5'd2, 1'b1, 32'h108, 1'b0, 1'b0);
    run("blt",  32'hFE41_C8E3, 32'h200, 0, 4, 2, 2, 5'd3, 5'd4, 1'b1, 32'h1F0, 1'b0, 1'b0);
    run("bltu", 32'hFE41_E8E3, 32'h200, 0, 4, 2, 2, 5'd3, 5'd4, 1'b0, 32'h1F0, 1'b0, 1'b0);
    run("bge",  32'hFE41_D8E3, 32'h200, 0, 4, 2, 2, 5'd3, 5'd4, 1'b0, 32'h1F0, 1'b0, 1'b0);
    run("bgeu", 32'hFE41_F8E3, 32'h200, 0, 4, 2, 2, 5'd3, 5'd4, 1'b1, 32'h1F0, 1'b0, 1'b0);
    run("bne_x0", 32'h0050_1263, 32'h300, 0, 4, 1, 1, 5'd5, 5'd0, 1'b0, 32'h304, 1'b0, 1'b0);

    rf_mem[2] = 32'h56;
    delay_addr = 5'd2;
    delay_val = 3;
    run("beq_slow", 32'h0020_8463, 32'h400, 5, 7, 5, 2, 5'd1, 5'd2, 1'b0, 32'h408, 1'b0, 1'b0);

    run("ill_f3",  32'h0020_A463, 32'h500, 0, 1, 0, 0, 5'd0, 5'd0, 1'b0, 32'h508, 1'b1, 1'b0);
    run("ill_opc", 32'h0020_8433, 32'h600, 0, 1, 0, 0, 5'd0, 5'd0, 1'b0, 32'h608, 1'b1, 1'b0);

    // Reset while waiting for the rs2 grant.
    delay_val = 5;
    sb.push_back('{taken: 1'b1, target: 32'h708, illegal: 1'b0, mis: 1'b0});
    in_valid = 1'b1; in_instr = 32'h0020_8463; in_pc = 32'h700;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("mid_rd2_req", {rf_req, rf_addr}, {1'b1, 5'd2});
    #2 rst = 1'b1;
    #1;
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_rf", {rf_req, rf_addr}, 0);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_outs", {out_taken, out_target, out_illegal, out_misaligned}, 0);
    void'(sb.pop_front());
    @(posedge clk); #1;
    rst = 1'b0;
    delay_val = 0;

    run("beq_mis", 32'h0010_8163, 32'h100, 0, 4, 2, 2, 5'd1, 5'd1, 1'b1, 32'h102, 1'b0, 1'b1);

    check("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
